// File: rtl/intermediate_signal_sweep_ctrl.sv
// Stimulus sequencer and checker for the 3-input intermediate-signal block
// (out_1 = in_1 & in_2 & in_3, out_2 = (in_1 & in_2) | in_3).
// A start pulse walks stim through vectors 0..7. Each vector is held for
// SETTLE idle cycles plus one check cycle. The DUT outputs are compared
// against a built-in golden model, and the error count plus the first
// failing vector are reported.
module intermediate_signal_sweep_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_out1,
    input  logic             dut_out2,
    output logic [2:0]       stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ERR_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // With no settle time, each vector goes straight to its check cycle.
    localparam logic [1:0] ST_AFTER_LOAD = (SETTLE_LD == 4'd0) ? ST_CHECK : ST_SETTLE;

    // Golden model of the block under test: bit0 = out_1, bit1 = out_2.
    function automatic logic [1:0] golden(input logic [2:0] v);
        golden = {(v[0] & v[1]) | v[2], v[0] & v[1] & v[2]};
    endfunction

    logic [1:0]       state_r;
    logic [3:0]       cnt_r;
    logic [2:0]       stim_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             ffv_r;
    logic [2:0]       ffvec_r;

    logic [1:0]       exp_s;
    logic             mismatch_s;
    logic [CNT_W-1:0] err_next_s;

    // Compare the DUT against the golden model and form the saturating error count.
    always_comb begin
        exp_s      = golden(stim_r);
        mismatch_s = (dut_out1 != exp_s[0]) | (dut_out2 != exp_s[1]);
        if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
            err_next_s = err_cnt_r + ERR_ONE;
        end else begin
            err_next_s = err_cnt_r;
        end
    end

    // Sweep sequencer: state, stimulus and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            stim_r    <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt_r <= ERR_ZERO;
            ffv_r     <= 1'b0;
            ffvec_r   <= 3'd0;
        end else if (busy_r && abort) begin
            // Abort leaves err_cnt and first_fail_* at their partial values.
            state_r <= ST_IDLE;
            stim_r  <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        state_r   <= ST_AFTER_LOAD;
                        cnt_r     <= SETTLE_LD;
                        stim_r    <= 3'd0;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        pass_r    <= 1'b0;
                        err_cnt_r <= ERR_ZERO;
                        ffv_r     <= 1'b0;
                        ffvec_r   <= 3'd0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_CHECK;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    err_cnt_r <= err_next_s;
                    if (mismatch_s && !ffv_r) begin
                        ffv_r   <= 1'b1;
                        ffvec_r <= stim_r;
                    end
                    if (stim_r == 3'd7) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == ERR_ZERO);
                    end else begin
                        state_r <= ST_AFTER_LOAD;
                        cnt_r   <= SETTLE_LD;
                        stim_r  <= stim_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    stim_r  <= 3'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stim             = stim_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_cnt          = err_cnt_r;
    assign first_fail_valid = ffv_r;
    assign first_fail_vec   = ffvec_r;

endmodule

// File: tb/tb_intermediate_signal_sweep_ctrl.sv
// Self-checking bench for intermediate_signal_sweep_ctrl.
// Instance A uses SETTLE=1, CNT_W=4. Instance B uses SETTLE=0, CNT_W=2.
// Each instance drives a behavioural block under test with a per-vector
// fault mask. Expected outputs come from cycle arithmetic and from counting
// the faulty vectors in that mask.
module tb_intermediate_signal_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [7:0] f1_a = 8'h00, f2_a = 8'h00, f1_b = 8'h00, f2_b = 8'h00;
    logic       out1_a, out2_a, out1_b, out2_b;
    logic [2:0] stim_a, stim_b, ffvec_a, ffvec_b;
    logic       busy_a, done_a, pass_a, ffv_a, busy_b, done_b, pass_b, ffv_b;
    logic [3:0] err_a;
    logic [1:0] err_b;
    int         cur = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Behavioural block under test, with optional per-vector output flips.
    assign out1_a = (stim_a[0] & stim_a[1] & stim_a[2]) ^ f1_a[stim_a];
    assign out2_a = ((stim_a[0] & stim_a[1]) | stim_a[2]) ^ f2_a[stim_a];
    assign out1_b = (stim_b[0] & stim_b[1] & stim_b[2]) ^ f1_b[stim_b];
    assign out2_b = ((stim_b[0] & stim_b[1]) | stim_b[2]) ^ f2_b[stim_b];

    intermediate_signal_sweep_ctrl #(.SETTLE(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .dut_out1(out1_a), .dut_out2(out2_a), .stim(stim_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

    intermediate_signal_sweep_ctrl #(.SETTLE(0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .dut_out1(out1_b), .dut_out2(out2_b), .stim(stim_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

    // The outputs of the instance selected by cur.
    logic [2:0] o_stim, o_ffvec;
    logic       o_busy, o_done, o_pass, o_ffv;
    logic [3:0] o_err;
    assign o_stim  = (cur == 0) ? stim_a  : stim_b;
    assign o_busy  = (cur == 0) ? busy_a  : busy_b;
    assign o_done  = (cur == 0) ? done_a  : done_b;
    assign o_pass  = (cur == 0) ? pass_a  : pass_b;
    assign o_ffv   = (cur == 0) ? ffv_a   : ffv_b;
    assign o_ffvec = (cur == 0) ? ffvec_a : ffvec_b;
    assign o_err   = (cur == 0) ? err_a   : {2'b00, err_b};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t observed=%0h expected=%0h", tag, cur, $time, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ab);
        start_a = (cur == 0) ? st : 1'b0;
        abort_a = (cur == 0) ? ab : 1'b0;
        start_b = (cur == 1) ? st : 1'b0;
        abort_b = (cur == 1) ? ab : 1'b0;
    endtask

    // Expected results after the first n vectors have been checked.
    task automatic model(input logic [7:0] mm, input int n, input int maxv,
                         output int err, output int ffv, output int ffvec);
        int cnt;
        cnt = 0; ffv = 0; ffvec = 0;
        for (int v = 0; v < n; v++) begin
            if (mm[v]) begin
                if (ffv == 0) begin ffv = 1; ffvec = v; end
                cnt++;
            end
        end
        err = (cnt > maxv) ? maxv : cnt;
    endtask

    task automatic check_results(input logic [7:0] mm, input int n, input int maxv, input int fin);
        int err, ffv, ffvec;
        model(mm, n, maxv, err, ffv, ffvec);
        check_eq("err_cnt", 32'(o_err), 32'(err));
        check_eq("ff_valid", 32'(o_ffv), 32'(ffv));
        check_eq("ff_vec", 32'(o_ffvec), 32'(ffvec));
        check_eq("pass", 32'(o_pass), 32'((fin != 0) && (err == 0)));
    endtask

    // Run one sweep on instance sel, checking all outputs every cycle.
    // start_at / abort_at: cycle index j at which to inject that request (-1 = never).
    task automatic run_sweep(input int sel, input logic [7:0] f1, input logic [7:0] f2,
                             input int start_at, input int abort_at);
        int s1, last, n;
        @(negedge clk);
        cur = sel;
        if (sel == 0) begin f1_a = f1; f2_a = f2; end
        else          begin f1_b = f1; f2_b = f2; end
        s1   = (sel == 0) ? 2 : 1;
        last = 8 * s1;
        drive(1'b1, 1'b0);
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            drive(1'b0, 1'b0);
            n = j / s1;
            check_eq("busy", 32'(o_busy), 32'(j < last));
            check_eq("done", 32'(o_done), 32'(j == last));
            check_eq("stim", 32'(o_stim), 32'((j < last) ? n : 7));
            check_results(f1 | f2, n, (sel == 0) ? 15 : 3, (j == last) ? 1 : 0);
            if (j == start_at) drive(1'b1, 1'b0);
            if (j == abort_at) begin
                drive(1'b0, 1'b1);
                @(negedge clk);
                drive(1'b0, 1'b0);
                check_eq("abort_busy", 32'(o_busy), 32'd0);
                check_eq("abort_done", 32'(o_done), 32'd0);
                check_eq("abort_stim", 32'(o_stim), 32'd0);
                check_results(f1 | f2, n, (sel == 0) ? 15 : 3, 0);
                return;
            end
        end
    endtask

    // Main test sequence.
    initial begin
        logic [7:0] r1, r2;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cur = i;
            check_eq("rst_busy", 32'(o_busy), 32'd0);
            check_eq("rst_stim", 32'(o_stim), 32'd0);
            check_results(8'h00, 0, 15, 0);
        end
        rst = 1'b0;

        // Asynchronous reset mid-sweep, taken at stim=4.
        @(negedge clk);
        cur = 0;
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        f2_a = 8'h01;
        repeat (8) @(negedge clk);
        check_eq("pre_rst_stim", 32'(o_stim), 32'd4);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_stim", 32'(o_stim), 32'd0);
        check_eq("arst_busy", 32'(o_busy), 32'd0);
        check_eq("arst_done", 32'(o_done), 32'd0);
        check_results(8'h00, 0, 15, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(o_busy), 32'd0);
        check_eq("idle_done", 32'(o_done), 32'd0);

        // Directed sweeps: correct block, out1 stuck at 0, out2 inverted.
        run_sweep(0, 8'h00, 8'h00, -1, -1);
        run_sweep(0, 8'h80, 8'h00, -1, -1);
        // abort has no effect in DONE.
        @(negedge clk);
        drive(1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0);
        check_eq("done_abort_done", 32'(o_done), 32'd1);
        check_eq("done_abort_stim", 32'(o_stim), 32'd7);
        run_sweep(1, 8'h00, 8'hFF, -1, -1);
        // Restart from DONE with SETTLE=0: results clear, then pass.
        run_sweep(1, 8'h00, 8'h00, -1, -1);

        // Handshake: start at stim=3 is ignored; abort in the stim=3 check cycle.
        run_sweep(0, 8'h08, 8'h02, 6, -1);
        run_sweep(0, 8'h0A, 8'h08, -1, 7);
        // abort together with start in IDLE: no sweep begins.
        @(negedge clk);
        drive(1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0);
        check_eq("ab_st_busy", 32'(o_busy), 32'd0);
        check_eq("ab_st_stim", 32'(o_stim), 32'd0);
        check_eq("ab_st_done", 32'(o_done), 32'd0);
        @(negedge clk);
        check_eq("ab_st_busy2", 32'(o_busy), 32'd0);

        // Randomized fault masks on both instances.
        for (int i = 0; i < 8; i++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin r1 = 8'h00; r2 = 8'h00; end
            run_sweep(i % 2, r1, r2, -1, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intermediate_signal_sweep_ctrl.md
# intermediate_signal_sweep_ctrl

Sequencer and checker for the 3-input intermediate-signal logic block (out_1 = in_1&in_2&in_3, out_2 = (in_1&in_2)|in_3). On a start pulse it drives all 8 input vectors in ascending order, holding each for a programmable settle time. It compares the block's outputs against an internal golden model and reports a pass/fail summary with the first failing vector. It replaces free-running testbench counters as the stimulus source and sits between the bench control logic and the device under test.

## Interface
- SETTLE, default 1: idle cycles each vector is held before it is checked; legal range 0..15.
- CNT_W, default 4: width of the error counter; the counter saturates.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  cancels a sweep in progress.
- dut_out1  in  1  out_1 from the DUT (combinational from stim).
- dut_out2  in  1  out_2 from the DUT.
- stim  out  3  registered stimulus; bit0→in_1, bit1→in_2, bit2→in_3.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next accepted start.
- pass  out  1  1 when done=1 and err_cnt=0.
- err_cnt  out  CNT_W  number of mismatching vectors; saturates at 2^CNT_W−1.
- first_fail_valid  out  1  at least one mismatch has occurred this sweep.
- first_fail_vec  out  3  stim value of the first mismatch.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE → start=1 (and abort=0): on that edge:
  - stim←0, busy←1, done←0, pass←0, err_cnt←0, first_fail_valid←0, first_fail_vec←0.
  - Settle counter←SETTLE.
  - Next state is SETTLE, or CHECK if SETTLE=0.
- SETTLE: counter decrements each cycle; when it reaches 1, the next state is CHECK. stim is stable throughout.
- CHECK (one cycle):
  - Compute expected values from the current stim.
  - Mismatch = (dut_out1≠exp1) | (dut_out2≠exp2). It counts once per vector, even if both outputs are wrong.
  - On mismatch: err_cnt increments, saturating. If first_fail_valid=0, capture first_fail_vec←stim and set first_fail_valid←1.
  - If stim=7: go to DONE; busy←0, done←1, pass←(final err_cnt=0).
  - Otherwise: stim←stim+1, reload the settle counter, return to SETTLE (or stay in CHECK if SETTLE=0).
- stim never wraps 7→0 within a sweep; it stays at 7 in DONE.
- start while busy: ignored.
- abort while busy: next edge goes to IDLE with stim←0, busy←0, done←0, pass←0. err_cnt and first_fail_* keep their partial values.
- abort in IDLE/DONE: no effect.
- abort and start in the same cycle: abort wins; no sweep starts.

## Timing
- Reset (async, immediate): state IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
- Reset mid-sweep discards all progress immediately.
- Start sampled at edge E0. Each vector is presented for SETTLE+1 cycles. The comparison is taken in the last of those cycles and registered at its closing edge.
- done rises after edge E0+8·(SETTLE+1):
  - SETTLE=1 → 16 edges.
  - SETTLE=0 → 8 edges.
- busy=1 from after E0 until done rises; busy and done are never both 1.
- err_cnt and first_fail_* update one edge after the CHECK cycle of the failing vector.
- The DUT must settle combinationally within a single cycle; SETTLE only covers external pipelining.

## Test plan
- Async reset: assert rst while stim=4 with no clock edge → all outputs read 0 immediately. After release, an idle clock leaves busy=0 and done=0.
- Correct DUT, SETTLE=1:
  - Drive a start pulse.
  - stim steps 0..7, each held 2 cycles.
  - done=1 at 16 edges after start; pass=1, err_cnt=0, first_fail_valid=0.
- dut_out1 forced to 0:
  - Only vector 7 mismatches.
  - err_cnt=1, first_fail_vec=7, first_fail_valid=1, pass=0.
- dut_out2 inverted, CNT_W=2:
  - All 8 vectors mismatch.
  - err_cnt saturates at 3, first_fail_vec=0, pass=0.
- Handshake:
  - A start at stim=3 is ignored.
  - abort at stim=3 → IDLE next edge, stim=0, busy=0, done=0.
  - abort together with start in IDLE → stays in IDLE.
- Restart from DONE with SETTLE=0:
  - Results clear on the start edge.
  - A new sweep completes in 8 edges with pass=1.
